// File: rtl/regfile_mp.sv
// Multi-ported register file: 2 read ports, 2 write ports,
// per-register pending (scoreboard) bits with a running count.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] dout1,
  output logic              rpend1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] dout2,
  output logic              rpend2,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] din0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] din1,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic              we0;
  logic              we1;
  logic              rsv_hit;
  logic              set_en;
  logic              dec0;
  logic              dec1;

  // Port 1 loses a same-address conflict, so it is masked here.
  assign we0 = wr0 && !(ZERO_REG != 0 && waddr0 == '0);
  assign we1 = wr1 && !(ZERO_REG != 0 && waddr1 == '0)
               && !(we0 && waddr0 == waddr1);

  assign rsv_hit = rsv && !pend[rsv_addr];
  assign rsv_ok  = rst_n && rsv_hit;
  assign set_en  = rsv_hit && !(ZERO_REG != 0 && rsv_addr == '0);

  // A set bit is never also pending, so set and clear cannot cancel.
  assign dec0 = we0 && pend[waddr0];
  assign dec1 = we1 && pend[waddr1];

  // Returns {pending, data} for one read address.
  function automatic logic [DATA_W:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = {pend[a], mem[a]};
    if (BYPASS != 0) begin
      if (we0 && waddr0 == a)
        r = {1'b0, din0};
      else if (we1 && waddr1 == a)
        r = {1'b0, din1};
    end
    if (ZERO_REG != 0 && a == '0)
      r = '0;
    if (!rst_n)
      r = '0;
    return r;
  endfunction

  // Combinational read ports with optional forwarding.
  always_comb begin
    {rpend1, dout1} = rd(raddr1);
    {rpend2, dout2} = rd(raddr2);
  end

  // Next pending vector: writes clear, accepted reservation sets last.
  always_comb begin
    pend_nxt = pend;
    if (we0)
      pend_nxt[waddr0] = 1'b0;
    if (we1)
      pend_nxt[waddr1] = 1'b0;
    if (set_en)
      pend_nxt[rsv_addr] = 1'b1;
  end

  // Word storage, port 0 written last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (we1)
        mem[waddr1] <= din1;
      if (we0)
        mem[waddr0] <= din0;
    end
  end

  // Pending bits and their incrementally maintained count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= pend_cnt
                  + {{ADDR_W{1'b0}}, set_en}
                  - {{ADDR_W{1'b0}}, dec0}
                  - {{ADDR_W{1'b0}}, dec1};
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and
// one non-bypassing instance driven by the same stimulus.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] raddr1, raddr2, waddr0, waddr1, rsv_addr;
  logic [DW-1:0] din0, din1;
  logic          wr0, wr1, rsv;

  logic [DW-1:0] a_dout1, a_dout2, b_dout1, b_dout2;
  logic          a_rpend1, a_rpend2, b_rpend1, b_rpend2;
  logic          a_rsv_ok, b_rsv_ok;
  logic [AW:0]   a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .dout1(a_dout1), .rpend1(a_rpend1),
    .raddr2(raddr2), .dout2(a_dout2), .rpend2(a_rpend2),
    .wr0(wr0), .waddr0(waddr0), .din0(din0),
    .wr1(wr1), .waddr1(waddr1), .din1(din1),
    .rsv(rsv), .rsv_addr(rsv_addr), .rsv_ok(a_rsv_ok),
    .pend_cnt(a_cnt)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .dout1(b_dout1), .rpend1(b_rpend1),
    .raddr2(raddr2), .dout2(b_dout2), .rpend2(b_rpend2),
    .wr0(wr0), .waddr0(waddr0), .din0(din0),
    .wr1(wr1), .waddr1(waddr1), .din1(din1),
    .rsv(rsv), .rsv_addr(rsv_addr), .rsv_ok(b_rsv_ok),
    .pend_cnt(b_cnt)
  );

  task automatic idle();
    wr0 = 0; waddr0 = '0; din0 = '0;
    wr1 = 0; waddr1 = '0; din1 = '0;
    rsv = 0; rsv_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    raddr1 = 5'd3; raddr2 = 5'd7;
    rsv = 1; rsv_addr = 5'd6;
    #2;
    total++; if (a_dout1 !== 32'h0) begin bad++; $display("FAIL rst_dout1 got=%h exp=0", a_dout1); end
    total++; if (a_dout2 !== 32'h0) begin bad++; $display("FAIL rst_dout2 got=%h exp=0", a_dout2); end
    total++; if (a_rpend1 !== 1'b0) begin bad++; $display("FAIL rst_rpend1 got=%b exp=0", a_rpend1); end
    total++; if (a_rsv_ok !== 1'b0) begin bad++; $display("FAIL rst_rsv_ok got=%b exp=0", a_rsv_ok); end
    total++; if (a_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    @(negedge clk);
    idle();
    #2 rst_n = 1;
    step();
  endtask

  task automatic test_write_read();
    wr0 = 1; waddr0 = 5'd5; din0 = 32'hDEADBEEF;
    step();
    idle(); raddr1 = 5'd5;
    #1;
    total++; if (a_dout1 !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd got=%h exp=deadbeef", a_dout1); end
  endtask

  task automatic test_conflict();
    wr0 = 1; waddr0 = 5'd7; din0 = 32'h11;
    wr1 = 1; waddr1 = 5'd7; din1 = 32'h22;
    step();
    idle(); raddr1 = 5'd7;
    #1;
    total++; if (a_dout1 !== 32'h11) begin bad++; $display("FAIL conflict got=%h exp=11", a_dout1); end
  endtask

  task automatic test_bypass();
    wr0 = 1; waddr0 = 5'd3; din0 = 32'h5A;
    step();
    idle();
    wr1 = 1; waddr1 = 5'd3; din1 = 32'hA5; raddr2 = 5'd3;
    #1;
    total++; if (a_dout2 !== 32'hA5) begin bad++; $display("FAIL bypass_on got=%h exp=a5", a_dout2); end
    total++; if (b_dout2 !== 32'h5A) begin bad++; $display("FAIL bypass_off got=%h exp=5a", b_dout2); end
    step();
    idle();
    #1;
    total++; if (b_dout2 !== 32'hA5) begin bad++; $display("FAIL bypass_after got=%h exp=a5", b_dout2); end
  endtask

  task automatic test_zero();
    wr0 = 1; waddr0 = 5'd0; din0 = 32'hFFFF; raddr1 = 5'd0;
    #1;
    total++; if (a_dout1 !== 32'h0) begin bad++; $display("FAIL zero_byp got=%h exp=0", a_dout1); end
    step();
    idle();
    #1;
    total++; if (b_dout1 !== 32'h0) begin bad++; $display("FAIL zero_rd got=%h exp=0", b_dout1); end
    total++; if (a_rpend1 !== 1'b0) begin bad++; $display("FAIL zero_pend got=%b exp=0", a_rpend1); end
    total++; if (a_cnt !== 6'd0) begin bad++; $display("FAIL zero_cnt got=%0d exp=0", a_cnt); end
    rsv = 1; rsv_addr = 5'd0;
    #1;
    total++; if (a_rsv_ok !== 1'b1) begin bad++; $display("FAIL zero_rsv_ok got=%b exp=1", a_rsv_ok); end
    step();
    idle();
    #1;
    total++; if (a_cnt !== 6'd0) begin bad++; $display("FAIL zero_rsv_cnt got=%0d exp=0", a_cnt); end
  endtask

  task automatic test_scoreboard();
    raddr1 = 5'd9;
    rsv = 1; rsv_addr = 5'd9;
    #1;
    total++; if (a_rsv_ok !== 1'b1) begin bad++; $display("FAIL sb_ok1 got=%b exp=1", a_rsv_ok); end
    step();
    #1;
    total++; if (a_cnt !== 6'd1) begin bad++; $display("FAIL sb_cnt1 got=%0d exp=1", a_cnt); end
    total++; if (a_rpend1 !== 1'b1) begin bad++; $display("FAIL sb_pend1 got=%b exp=1", a_rpend1); end
    total++; if (a_rsv_ok !== 1'b0) begin bad++; $display("FAIL sb_ok2 got=%b exp=0", a_rsv_ok); end
    step();
    idle();
    #1;
    total++; if (a_cnt !== 6'd1) begin bad++; $display("FAIL sb_retry_cnt got=%0d exp=1", a_cnt); end
    wr0 = 1; waddr0 = 5'd9; din0 = 32'h99;
    #1;
    total++; if (a_rpend1 !== 1'b0) begin bad++; $display("FAIL sb_byp_pend got=%b exp=0", a_rpend1); end
    total++; if (b_rpend1 !== 1'b1) begin bad++; $display("FAIL sb_nobyp_pend got=%b exp=1", b_rpend1); end
    step();
    idle();
    #1;
    total++; if (a_rpend1 !== 1'b0) begin bad++; $display("FAIL sb_clr_pend got=%b exp=0", a_rpend1); end
    total++; if (a_cnt !== 6'd0) begin bad++; $display("FAIL sb_clr_cnt got=%0d exp=0", a_cnt); end
    rsv = 1; rsv_addr = 5'd9;
    wr0 = 1; waddr0 = 5'd9; din0 = 32'h77;
    step();
    idle();
    #1;
    total++; if (a_rpend1 !== 1'b1) begin bad++; $display("FAIL sb_setwin_pend got=%b exp=1", a_rpend1); end
    total++; if (b_dout1 !== 32'h77) begin bad++; $display("FAIL sb_setwin_data got=%h exp=77", b_dout1); end
    total++; if (a_cnt !== 6'd1) begin bad++; $display("FAIL sb_setwin_cnt got=%0d exp=1", a_cnt); end
    rsv = 1; rsv_addr = 5'd10;
    step();
    idle();
    #1;
    total++; if (a_cnt !== 6'd2) begin bad++; $display("FAIL sb_cnt2 got=%0d exp=2", a_cnt); end
    wr0 = 1; waddr0 = 5'd9;  din0 = 32'h1;
    wr1 = 1; waddr1 = 5'd10; din1 = 32'h2;
    step();
    idle();
    #1;
    total++; if (a_cnt !== 6'd0) begin bad++; $display("FAIL sb_dual_clr got=%0d exp=0", a_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) begin
      rsv = 1; rsv_addr = 5'(i);
      step();
    end
    idle();
    raddr1 = 5'd5; raddr2 = 5'd3;
    #1;
    total++; if (a_cnt !== 6'd4) begin bad++; $display("FAIL mid_cnt4 got=%0d exp=4", a_cnt); end
    #2 rst_n = 0;
    #1;
    total++; if (a_cnt !== 6'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", a_cnt); end
    total++; if (b_cnt !== 6'd0) begin bad++; $display("FAIL mid_cnt_b got=%0d exp=0", b_cnt); end
    total++; if (a_dout1 !== 32'h0) begin bad++; $display("FAIL mid_dout1 got=%h exp=0", a_dout1); end
    total++; if (a_dout2 !== 32'h0) begin bad++; $display("FAIL mid_dout2 got=%h exp=0", a_dout2); end
    @(negedge clk);
    wr0 = 1; waddr0 = 5'd12; din0 = 32'h12;
    rsv = 1; rsv_addr = 5'd13;
    rst_n = 1;
    step();
    idle();
    raddr1 = 5'd12; raddr2 = 5'd13;
    #1;
    total++; if (b_dout1 !== 32'h12) begin bad++; $display("FAIL post_rst_wr got=%h exp=12", b_dout1); end
    total++; if (a_rpend2 !== 1'b1) begin bad++; $display("FAIL post_rst_rsv got=%b exp=1", a_rpend2); end
    total++; if (a_cnt !== 6'd1) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=1", a_cnt); end
    total++; if (b_dout2 !== 32'h0) begin bad++; $display("FAIL post_rst_clr got=%h exp=0", b_dout2); end
  endtask

  initial begin
    raddr1 = '0; raddr2 = '0;
    test_reset();
    test_write_read();
    test_conflict();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, default 32, word width.
- ADDR_W, default 5, address width; depth = 2**ADDR_W.
- ZERO_REG, default 1, register 0 hard-wired to zero when 1.
- BYPASS, default 1, write-to-read forwarding when 1.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- raddr1  in  ADDR_W  read port 1 address.
- dout1  out  DATA_W  read port 1 data.
- rpend1  out  1  register at raddr1 pending (reserved, not yet written).
- raddr2  in  ADDR_W  read port 2 address.
- dout2  out  DATA_W  read port 2 data.
- rpend2  out  1  register at raddr2 pending.
- wr0  in  1  write port 0 enable.
- waddr0  in  ADDR_W  write port 0 address.
- din0  in  DATA_W  write port 0 data.
- wr1  in  1  write port 1 enable.
- waddr1  in  ADDR_W  write port 1 address.
- din1  in  DATA_W  write port 1 data.
- rsv  in  1  reservation request.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle.
- pend_cnt  out  ADDR_W+1  number of pending registers.

Function
REQ-003 Storage SHALL be 2**ADDR_W words of DATA_W bits plus one pending bit per word.
REQ-004 Writes SHALL be synchronous: on a rising edge with wrN=1, word[waddrN] <= dinN.
REQ-005 When wr0 and wr1 target the same address in one cycle, port 0 SHALL win; port 1 data is discarded.
REQ-006 Reads SHALL be combinational: doutN = word[raddrN]; rpendN = pend[raddrN].
REQ-007 With BYPASS=1, a read matching an active write address in the same cycle SHALL return that write's data (port 0 over port 1) and rpendN=0.
REQ-008 With BYPASS=0, same-cycle reads SHALL return the old contents and the old pending bit.
REQ-009 With ZERO_REG=1: writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, pend[0] SHALL stay 0, and reservations of address 0 SHALL be accepted with no state change.
REQ-010 rsv_ok SHALL be combinational: rsv && !pend[rsv_addr], ignoring same-cycle writes.
REQ-011 When rsv_ok=1, pend[rsv_addr] SHALL be set at the clock edge.
REQ-012 When rsv=1 and rsv_ok=0, state SHALL be unchanged; the requester retries.
REQ-013 A write to address A SHALL clear pend[A] at the same edge.
REQ-014 When an accepted reservation and a write hit the same address in one cycle, the word SHALL be written and pend SHALL end at 1 (set wins).
REQ-015 pend_cnt SHALL be a registered count equal to the number of set pending bits after each edge.
REQ-016 pend_cnt SHALL be updated incrementally: +1 per newly set bit, -1 per bit cleared (up to two per cycle), net per cycle.
REQ-017 pend_cnt SHALL never wrap; its maximum is 2**ADDR_W (2**ADDR_W-1 with ZERO_REG=1).

Reset
REQ-018 While rst_n=0, all words, all pending bits and pend_cnt SHALL be 0 immediately, independent of clk.
REQ-019 While rst_n=0, rsv_ok, rpend1, rpend2, dout1 and dout2 SHALL read 0.
REQ-020 Writes and reservations presented in the cycle rst_n deasserts SHALL take effect at the first rising edge after deassertion.
REQ-021 Reset asserted mid-operation SHALL discard all pending reservations.

Verification
REQ-022 Directed scenarios, defaults, the bench SHALL cover:
- Write/read: wr0 waddr0=5 din0=0xDEADBEEF; next cycle raddr1=5 -> dout1=0xDEADBEEF.
- Write conflict: wr0 and wr1 both to addr 7, din0=0x11, din1=0x22 -> word[7]=0x11.
- Bypass: same cycle wr1 waddr1=3 din1=0xA5, raddr2=3 -> dout2=0xA5; repeat with BYPASS=0 -> old value.
- Zero register: write 0xFFFF to addr 0 -> dout1=0, rpend1=0, pend_cnt unchanged.
- Scoreboard: reserve 9 -> rsv_ok=1, pend_cnt=1; reserve 9 again -> rsv_ok=0; write 9 -> rpend=0, pend_cnt=0; reserve+write 9 same cycle -> pend[9]=1.
- Reset: reserve 4 registers, assert rst_n=0 between edges -> pend_cnt=0 and all dout=0 immediately.
